// File: rtl/ahb_dma_req_pkg.sv
// Shared types and constants for the peripheral-side DMA request logic.
package ahb_dma_req_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_ASSERT,
        REQ_GAP
    } dma_req_state_t;

    // Which direction's request is older and so owns the next acknowledge.
    typedef enum logic {
        ACK_SRC,
        ACK_DST
    } ack_owner_t;

    localparam int GAP_W = 4;

endpackage

// File: rtl/ahb_dma_req_fsm.sv
// One direction of the DMA request handshake: raise on cond, hold until ack,
// then keep the request low for a minimum gap and time the wait for ack.
module ahb_dma_req_fsm
    import ahb_dma_req_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TMO_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cond,
    input  logic             ack,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             req,
    output logic             start,
    output logic             busy_nxt,
    output logic             tmo_hit
);

    dma_req_state_t   state;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        start    = 1'b0;
        busy_nxt = 1'b0;
        tmo_nxt  = '0;
        case (state)
            REQ_IDLE: begin
                start    = cond;
                busy_nxt = cond;
                if (cond) begin
                    tmo_nxt = TMO_W'(1);
                end
            end
            REQ_ASSERT: begin
                busy_nxt = !(ack && GAP_CYCLES == 1);
                if (!ack) begin
                    tmo_nxt = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
                end
            end
            REQ_GAP: begin
                busy_nxt = (gap_cnt != GAP_W'(1));
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
        // tmo_nxt is the number of cycles the request will have been high next cycle.
        tmo_hit = (tmo_limit != '0) && (tmo_nxt == tmo_limit);
    end

    // The low cycle in which IDLE samples cond counts as the last gap cycle,
    // so a persisting cond gives exactly GAP_CYCLES low cycles after an ack.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ_IDLE;
            req     <= 1'b0;
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_nxt;
            case (state)
                REQ_IDLE: begin
                    if (cond) begin
                        state <= REQ_ASSERT;
                        req   <= 1'b1;
                    end
                end
                REQ_ASSERT: begin
                    if (ack) begin
                        req     <= 1'b0;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= (GAP_CYCLES > 1) ? REQ_GAP : REQ_IDLE;
                    end
                end
                REQ_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state   <= REQ_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= REQ_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_dma_periph_req.sv
// Peripheral-side DMA request generator: RX-data source request, TX-space
// destination request, acknowledge steering and a sticky request timeout.
module ahb_dma_periph_req
    import ahb_dma_req_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1),
    parameter int GAP_CYCLES = 2,
    parameter int TMO_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_en,
    input  logic             dst_en,
    input  logic [LVL_W-1:0] rx_level,
    input  logic [LVL_W-1:0] tx_level,
    input  logic [LVL_W-1:0] rx_thresh,
    input  logic [LVL_W-1:0] tx_thresh,
    input  logic             rx_flush,
    input  logic             ack_i,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             src_req_o,
    output logic             dst_req_o,
    output logic             busy_o,
    output logic             tmo_err_o,
    input  logic             tmo_clr
);

    localparam int FREE_W = LVL_W + 1;

    logic [LVL_W-1:0]  rx_th_eff;
    logic [LVL_W-1:0]  tx_th_eff;
    logic [FREE_W-1:0] tx_free;
    logic              src_cond;
    logic              dst_cond;
    logic              src_ack;
    logic              dst_ack;
    logic              src_start;
    logic              dst_start;
    logic              src_busy_nxt;
    logic              dst_busy_nxt;
    logic              src_hit;
    logic              dst_hit;
    ack_owner_t        older;

    always_comb begin
        rx_th_eff = (rx_thresh == '0) ? LVL_W'(1) : rx_thresh;
        tx_th_eff = (tx_thresh == '0) ? LVL_W'(1) : tx_thresh;
        // An out-of-range TX level reports no free space rather than wrapping.
        if ({1'b0, tx_level} > FREE_W'(FIFO_DEPTH)) begin
            tx_free = '0;
        end else begin
            tx_free = FREE_W'(FIFO_DEPTH) - {1'b0, tx_level};
        end
        src_cond = src_en && ((rx_level >= rx_th_eff) || (rx_flush && rx_level != '0));
        dst_cond = dst_en && (tx_free >= {1'b0, tx_th_eff});
        src_ack  = ack_i && src_req_o && (!dst_req_o || older == ACK_SRC);
        dst_ack  = ack_i && dst_req_o && (!src_req_o || older == ACK_DST);
    end

    ahb_dma_req_fsm #(
        .GAP_CYCLES (GAP_CYCLES),
        .TMO_W      (TMO_W)
    ) u_src (
        .clk       (clk),
        .rst       (rst),
        .cond      (src_cond),
        .ack       (src_ack),
        .tmo_limit (tmo_limit),
        .req       (src_req_o),
        .start     (src_start),
        .busy_nxt  (src_busy_nxt),
        .tmo_hit   (src_hit)
    );

    ahb_dma_req_fsm #(
        .GAP_CYCLES (GAP_CYCLES),
        .TMO_W      (TMO_W)
    ) u_dst (
        .clk       (clk),
        .rst       (rst),
        .cond      (dst_cond),
        .ack       (dst_ack),
        .tmo_limit (tmo_limit),
        .req       (dst_req_o),
        .start     (dst_start),
        .busy_nxt  (dst_busy_nxt),
        .tmo_hit   (dst_hit)
    );

    // Simultaneous rises leave src as the older request, matching the
    // selector's source-then-destination phase order.
    always_ff @(posedge clk) begin
        if (rst) begin
            older     <= ACK_SRC;
            busy_o    <= 1'b0;
            tmo_err_o <= 1'b0;
        end else begin
            if (dst_start) begin
                older <= ACK_SRC;
            end else if (src_start && dst_req_o) begin
                older <= ACK_DST;
            end
            busy_o    <= src_busy_nxt || dst_busy_nxt;
            tmo_err_o <= (tmo_err_o && !tmo_clr) || src_hit || dst_hit;
        end
    end

endmodule

// File: tb/tb_ahb_dma_periph_req.sv
// Self-checking bench for ahb_dma_periph_req: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_ahb_dma_periph_req;

    localparam int DEPTH   = 16;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int GAP     = 2;
    localparam int TMO_W   = 16;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             src_en;
    logic             dst_en;
    logic [LVL_W-1:0] rx_level;
    logic [LVL_W-1:0] tx_level;
    logic [LVL_W-1:0] rx_thresh;
    logic [LVL_W-1:0] tx_thresh;
    logic             rx_flush;
    logic             ack_i;
    logic [TMO_W-1:0] tmo_limit;
    logic             tmo_clr;
    logic             src_req_o;
    logic             dst_req_o;
    logic             busy_o;
    logic             tmo_err_o;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    ahb_dma_periph_req #(
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LVL_W),
        .GAP_CYCLES (GAP),
        .TMO_W      (TMO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_en    (src_en),
        .dst_en    (dst_en),
        .rx_level  (rx_level),
        .tx_level  (tx_level),
        .rx_thresh (rx_thresh),
        .tx_thresh (tx_thresh),
        .rx_flush  (rx_flush),
        .ack_i     (ack_i),
        .tmo_limit (tmo_limit),
        .src_req_o (src_req_o),
        .dst_req_o (dst_req_o),
        .busy_o    (busy_o),
        .tmo_err_o (tmo_err_o),
        .tmo_clr   (tmo_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: each direction is described by whether its request is
    // high, how many low cycles have passed since its last ack, how long it has
    // been waiting, and the cycle it was raised (older request takes the ack).
    bit m_req   [2];
    int m_lows  [2];
    int m_age   [2];
    int m_stamp [2];
    bit m_flag;
    int cyc = 0;

    always @(posedge clk) begin : model
        bit c [2];
        bit a [2];
        bit hit;
        int free, rt, tt;
        cyc++;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_req[d]   = 1'b0;
                m_lows[d]  = GAP;
                m_age[d]   = 0;
                m_stamp[d] = 0;
            end
            m_flag = 1'b0;
        end else begin
            rt   = (rx_thresh == 0) ? 1 : int'(rx_thresh);
            tt   = (tx_thresh == 0) ? 1 : int'(tx_thresh);
            free = (int'(tx_level) > DEPTH) ? 0 : DEPTH - int'(tx_level);
            c[0] = src_en && ((int'(rx_level) >= rt) || (rx_flush && rx_level != 0));
            c[1] = dst_en && (free >= tt);
            a[0] = ack_i && m_req[0] && (!m_req[1] || m_stamp[0] <= m_stamp[1]);
            a[1] = ack_i && m_req[1] && (!m_req[0] || m_stamp[1] < m_stamp[0]);
            hit  = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (m_req[d]) begin
                    if (a[d]) begin
                        m_req[d]  = 1'b0;
                        m_lows[d] = 1;
                        m_age[d]  = 0;
                    end else if (m_age[d] < TMO_MAX) begin
                        m_age[d]++;
                    end
                end else if (m_lows[d] >= GAP && c[d]) begin
                    m_req[d]   = 1'b1;
                    m_stamp[d] = cyc;
                    m_age[d]   = 1;
                end else if (m_lows[d] < 1000) begin
                    m_lows[d]++;
                end
                if (m_req[d] && tmo_limit != 0 && m_age[d] == int'(tmo_limit)) hit = 1'b1;
            end
            m_flag = (m_flag && !tmo_clr) || hit;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_src_req", src_req_o, m_req[0]);
            check("cyc_dst_req", dst_req_o, m_req[1]);
            check("cyc_busy", busy_o,
                  m_req[0] || m_req[1] || m_lows[0] < GAP || m_lows[1] < GAP);
            check("cyc_tmo_err", tmo_err_o, m_flag);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        step(1);
        ack_i = 1'b0;
    endtask

    task automatic quiesce();
        src_en   = 1'b0;
        dst_en   = 1'b0;
        rx_flush = 1'b0;
        ack_i    = 1'b0;
        tmo_clr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_req[0] || m_req[1]) pulse_ack();
            else step(1);
        end
        step(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; src_en = 1'b0; dst_en = 1'b0; rx_flush = 1'b0; ack_i = 1'b0;
        rx_level = '0; tx_level = 5'd16; rx_thresh = '0; tx_thresh = '0;
        tmo_limit = '0; tmo_clr = 1'b0;
        step(1);
        cmp_en = 1'b1;
        check("reset_src_req", src_req_o, 0);
        check("reset_dst_req", dst_req_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_tmo", tmo_err_o, 0);
        step(1);
        rst = 1'b0;
        step(2);

        // RX watermark ramp, ack, fixed two-cycle gap, re-raise
        rx_thresh = 5'd4;
        src_en    = 1'b1;
        for (int lvl = 0; lvl < 4; lvl++) begin
            rx_level = LVL_W'(lvl);
            step(1);
            check("t1_below_thresh", src_req_o, 0);
        end
        rx_level = 5'd4;
        step(1);
        check("t1_rise", src_req_o, 1);
        pulse_ack();
        check("t1_ack_low", src_req_o, 0);
        step(1);
        check("t1_gap_low", src_req_o, 0);
        step(1);
        check("t1_rearm", src_req_o, 1);
        quiesce();

        // TX free space, no withdrawal, out-of-range level
        tx_level = 5'd14; tx_thresh = 5'd2; dst_en = 1'b1;
        step(1);
        check("t2_dst_rise", dst_req_o, 1);
        tx_level = 5'd15;
        step(3);
        check("t2_held", dst_req_o, 1);
        pulse_ack();
        check("t2_ack_low", dst_req_o, 0);
        step(3);
        check("t2_no_space", dst_req_o, 0);
        tx_level = 5'd17;
        step(4);
        check("t2_out_of_range", dst_req_o, 0);
        check("t2_idle_busy", busy_o, 0);
        quiesce();

        // Flush requests below the watermark
        rx_thresh = 5'd8; rx_level = 5'd1; rx_flush = 1'b1; src_en = 1'b1;
        step(1);
        check("t3_flush_req", src_req_o, 1);
        rx_flush = 1'b0;
        pulse_ack();
        step(4);
        check("t3_no_flush", src_req_o, 0);
        quiesce();

        // Same-cycle rise: src acked first; then dst older by 3 cycles
        rx_level = 5'd4; rx_thresh = 5'd4; tx_level = 5'd0; tx_thresh = 5'd1;
        src_en = 1'b1; dst_en = 1'b1;
        step(1);
        src_en = 1'b0; dst_en = 1'b0;
        check("t4_both_src", src_req_o, 1);
        check("t4_both_dst", dst_req_o, 1);
        pulse_ack();
        check("t4_first_src", src_req_o, 0);
        check("t4_first_dst", dst_req_o, 1);
        pulse_ack();
        check("t4_second_dst", dst_req_o, 0);
        quiesce();
        dst_en = 1'b1;
        step(3);
        dst_en = 1'b0; src_en = 1'b1;
        step(1);
        src_en = 1'b0;
        check("t4_late_src", src_req_o, 1);
        pulse_ack();
        check("t4_older_dst", dst_req_o, 0);
        check("t4_younger_src", src_req_o, 1);
        pulse_ack();
        check("t4_src_done", src_req_o, 0);
        quiesce();

        // Timeout on the 10th request cycle, sticky, clear, disabled
        tmo_limit = 16'd10; rx_level = 5'd4; rx_thresh = 5'd4; src_en = 1'b1;
        step(1);
        src_en = 1'b0;
        check("t5_req", src_req_o, 1);
        step(8);
        check("t5_cycle9", tmo_err_o, 0);
        step(1);
        check("t5_cycle10", tmo_err_o, 1);
        check("t5_req_kept", src_req_o, 1);
        step(3);
        check("t5_sticky", tmo_err_o, 1);
        tmo_clr = 1'b1;
        step(1);
        tmo_clr = 1'b0;
        check("t5_cleared", tmo_err_o, 0);
        pulse_ack();
        quiesce();
        tmo_limit = '0; src_en = 1'b1;
        step(1);
        src_en = 1'b0;
        step(20);
        check("t5_disabled", tmo_err_o, 0);
        check("t5_disabled_req", src_req_o, 1);
        pulse_ack();
        quiesce();

        // Reset while both requests are high
        tmo_limit = 16'd3; tx_level = 5'd0; src_en = 1'b1; dst_en = 1'b1;
        step(1);
        src_en = 1'b0; dst_en = 1'b0;
        step(3);
        check("t6_tmo_before", tmo_err_o, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_src", src_req_o, 0);
        check("t6_dst", dst_req_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_tmo", tmo_err_o, 0);
        pulse_ack();
        check("t6_ack_ignored_busy", busy_o, 0);
        check("t6_ack_ignored_src", src_req_o, 0);
        tmo_limit = '0;
        step(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                tmo_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : TMO_W'($urandom_range(1, 20));
            end
            src_en    = ($urandom_range(0, 3) != 0);
            dst_en    = ($urandom_range(0, 3) != 0);
            rx_level  = LVL_W'($urandom_range(0, 17));
            tx_level  = LVL_W'($urandom_range(0, 17));
            rx_thresh = LVL_W'($urandom_range(0, 16));
            tx_thresh = LVL_W'($urandom_range(0, 16));
            rx_flush  = ($urandom_range(0, 3) == 0);
            ack_i     = ($urandom_range(0, 2) == 0);
            tmo_clr   = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst = 1'b0; ack_i = 1'b0; tmo_clr = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_dma_periph_req.md
Name: ahb_dma_periph_req

Overview:
- Peripheral-side end of the DMA request/acknowledge handshake.
- Generates the source request (RX FIFO has data) and the destination request (TX FIFO has space) for one DMA channel.
- Drives the channel's req_i and dma_dst_req bits; consumes that channel's ack_o bit.
- Instantiated inside each DMA-capable AHB peripheral (UART, SPI, ...), next to its FIFOs.

Parameters:
- FIFO_DEPTH, 16, entries in each of the peripheral's RX/TX FIFOs.
- LVL_W, $clog2(FIFO_DEPTH+1), width of level and threshold ports.
- GAP_CYCLES, 2, minimum request-low cycles after each ack, so the selector's req_r/ack_o pipeline clears; range 1..15.
- TMO_W, 16, width of the request-timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- src_en  in  1  enable source (RX) requests
- dst_en  in  1  enable destination (TX) requests
- rx_level  in  LVL_W  current RX FIFO occupancy
- tx_level  in  LVL_W  current TX FIFO occupancy
- rx_thresh  in  LVL_W  RX watermark, 0 treated as 1
- tx_thresh  in  LVL_W  TX free-space watermark, 0 treated as 1
- rx_flush  in  1  request on any RX data below watermark (end of frame)
- ack_i  in  1  one-cycle acknowledge from the DMA channel select
- tmo_limit  in  TMO_W  cycles a request may stay unacknowledged, 0 disables
- src_req_o  out  1  to DMA req_i bit
- dst_req_o  out  1  to DMA dma_dst_req bit
- busy_o  out  1  either FSM not in IDLE
- tmo_err_o  out  1  sticky timeout flag
- tmo_clr  in  1  clears tmo_err_o

Behaviour:
Reset and registered outputs
- Reset is synchronous on rst=1: both FSMs go to IDLE; all outputs are 0; counters are 0.
- All outputs are registered.

Per-direction FSM (identical for src and dst); states IDLE, REQ, GAP
- Trigger conditions:
  - src_cond = src_en & ((rx_level >= max(rx_thresh,1)) | (rx_flush & rx_level != 0)).
  - dst_cond = dst_en & ((FIFO_DEPTH - tx_level) >= max(tx_thresh,1)).
  - Compute the subtraction at LVL_W+1 bits. tx_level > FIFO_DEPTH yields free = 0.
- IDLE -> REQ when cond=1. The req output rises the cycle after cond is sampled (1-cycle latency).
- REQ: req held high until the acknowledge.
  - Req is never withdrawn once raised, even if en or cond drops.
- REQ -> GAP on ack_i=1. The req output is low the next cycle.
- GAP: req low; gap counter counts GAP_CYCLES cycles, then -> IDLE. Cond is re-evaluated only in IDLE.

Acknowledge routing
- ack_i is routed to the src FSM when only it is in REQ, and likewise for dst.
- If both are in REQ, ack_i goes to the FSM whose request rose first. If they rose on the same cycle, src wins (mirrors the selector toggling between source and destination phases).
- ack_i in IDLE/GAP is ignored.
- src_req_o and dst_req_o may be high simultaneously.

Timeout
- Per-FSM counter increments each cycle in REQ and clears on leaving REQ.
- When tmo_limit != 0 and the counter reaches tmo_limit, tmo_err_o is set sticky. The request stays asserted.
- The counter saturates and does not wrap.
- tmo_clr clears the flag. If set and clear occur in the same cycle, set wins.

Mid-operation reset
- rst during REQ drops req the next edge. No ack is expected afterwards.

busy_o = (src_state != IDLE) | (dst_state != IDLE).

Decomposition:
- Package ahb_dma_req_pkg holds:
  - typedef enum logic [1:0] {REQ_IDLE, REQ_ASSERT, REQ_GAP} dma_req_state_t;
  - localparam GAP_W = 4.
- Sub-module ahb_dma_req_fsm holds one direction: FSM, gap counter, timeout counter, and a cond/ack/req/tmo_hit interface.
- Top instantiates it twice and adds the ack steering (first-raised tracker) and the sticky timeout flag.

Test Plan:
1. rx_thresh=4, rx_level ramps 0..4 with src_en=1 -> src_req_o rises 1 cycle after level=4. ack_i pulse -> req low next cycle, low for exactly 2 cycles, then re-raised if level is still >=4.
2. tx_level=14, tx_thresh=2, FIFO_DEPTH=16 -> dst_req_o=1. Then tx_level=15 -> dst_req_o=0 only after the ack (no withdrawal). tx_level=17 (out of range) -> no request.
3. rx_level=1, rx_thresh=8, rx_flush=1 -> src_req_o=1. rx_flush=0 with level 1 -> no request.
4. src and dst conditions true on the same cycle -> both req high. First ack_i clears src only, second ack_i clears dst. Dst first by 3 cycles -> first ack clears dst.
5. tmo_limit=10, no ack -> tmo_err_o=1 on the 10th cycle in REQ, req stays high. tmo_clr pulse -> flag 0. tmo_limit=0 -> flag never sets.
6. rst=1 for one cycle while both requests are high -> all outputs 0 next edge. ack_i afterwards is ignored and busy_o=0.
